// File: rtl/inst_queue_if.sv
// Decode/issue-side bus of the instruction queue, with the controller's stall and flush controls.
interface inst_queue_if #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 64
) ();
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic             push_en;
  logic [WIDTH-1:0] push_data;
  logic             stall_push;
  logic             pop_en;
  logic             stall_pop;
  logic             flush;
  logic             head_valid;
  logic [WIDTH-1:0] head_data;
  logic             iq_full;
  logic             iq_empty;
  logic [CW-1:0]    iq_count;

  // Pipeline side: decode pushes, issue pops, controller stalls and flushes.
  modport master (
    output push_en, push_data, stall_push, pop_en, stall_pop, flush,
    input  head_valid, head_data, iq_full, iq_empty, iq_count
  );

  // Queue side.
  modport slave (
    input  push_en, push_data, stall_push, pop_en, stall_pop, flush,
    output head_valid, head_data, iq_full, iq_empty, iq_count
  );
endinterface

// File: rtl/inst_queue.sv
// Instruction queue between decode and issue: circular FIFO with first-word fall-through head.
// Flush beats push/pop and stalls; a push into a full queue is dropped even if a pop is accepted.
module inst_queue #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 64
) (
  input logic         clk,
  input logic         resetn,
  inst_queue_if.slave iq
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             full;
  logic             nonempty;
  logic             push_acc;
  logic             pop_acc;
  logic [CW-1:0]    count_nxt;

  assign full     = (count == CW'(DEPTH));
  assign nonempty = (count != '0);

  // Handshake acceptance; flush discards any same-cycle push or pop.
  assign push_acc = iq.push_en & ~iq.stall_push & ~full     & ~iq.flush;
  assign pop_acc  = iq.pop_en  & ~iq.stall_pop  & nonempty  & ~iq.flush;

  // Occupancy update: simultaneous push and pop leave it unchanged.
  always_comb begin
    count_nxt = count;
    case ({push_acc, pop_acc})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // Pointer and occupancy state; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (iq.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + AW'(1);
      if (pop_acc)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
    end
  end

  // Entry storage, intentionally not reset.
  always_ff @(posedge clk) begin
    if (push_acc) mem[wr_ptr] <= iq.push_data;
  end

  // Status and head outputs derive from registered state only.
  assign iq.head_valid = nonempty;
  assign iq.head_data  = nonempty ? mem[rd_ptr] : '0;
  assign iq.iq_full    = full;
  assign iq.iq_empty   = ~nonempty;
  assign iq.iq_count   = count;
endmodule
